// File: rtl/char_line_scanner_pkg.sv
// Shared types and constants for the single-line text glyph scanner.
// Glyph ROM is 64x8: {code[1:0], glyph_row[3:0]} -> one 8-pixel row, MSB leftmost.
package char_line_scanner_pkg;

    localparam int GLYPH_W    = 8;
    localparam int GLYPH_ROWS = 16;
    localparam int CODE_W     = 2;
    localparam int ROM_AW     = 6;
    localparam int ROW_W      = 4;
    localparam int IDX_W      = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREFETCH = 3'd1,
        ST_LOAD     = 3'd2,
        ST_RUN      = 3'd3,
        ST_DONE     = 3'd4
    } scan_state_e;

    function automatic logic [ROM_AW-1:0] rom_addr_f(input logic [CODE_W-1:0] code,
                                                     input logic [ROW_W-1:0]  row);
        return {code, row};
    endfunction

endpackage

// File: rtl/char_line_scanner_if.sv
// Timing strobes, text-buffer write port, glyph-ROM port and pixel output of the scanner.
// master = timing source / ROM side, slave = the scanner itself.
interface char_line_scanner_if;
    import char_line_scanner_pkg::*;

    logic                frame_start;
    logic                line_start;
    logic                pixel_en;
    logic                wr_en;
    logic [IDX_W-1:0]    wr_idx;
    logic [CODE_W-1:0]   wr_code;
    logic [ROM_AW-1:0]   rom_addr;
    logic [GLYPH_W-1:0]  rom_data;
    logic                pixel;
    logic                text_active;

    modport master (
        output frame_start, line_start, pixel_en, wr_en, wr_idx, wr_code, rom_data,
        input  rom_addr, pixel, text_active
    );

    modport slave (
        input  frame_start, line_start, pixel_en, wr_en, wr_idx, wr_code, rom_data,
        output rom_addr, pixel, text_active
    );

endinterface

// File: rtl/char_line_scanner_text.sv
// Double-buffered text line: writes go to the shadow copy, which becomes the
// displayed (active) copy at frame start so a frame never shows a half-updated line.
module char_text_buffer
    import char_line_scanner_pkg::*;
#(
    parameter int NUM_CHARS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              srst,
    input  logic              frame_start,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [CODE_W-1:0] wr_code,
    output logic [CODE_W-1:0] active_code [NUM_CHARS]
);

    logic [CODE_W-1:0] shadow_r [NUM_CHARS];
    logic [CODE_W-1:0] active_r [NUM_CHARS];

    // Copy reads the old shadow, so a write in the frame-start cycle only shows next frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CHARS; i++) begin
                shadow_r[i] <= '0;
                active_r[i] <= '0;
            end
        end else if (srst) begin
            for (int i = 0; i < NUM_CHARS; i++) begin
                shadow_r[i] <= '0;
                active_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CHARS; i++) begin
                if (frame_start) begin
                    active_r[i] <= shadow_r[i];
                end
                if (wr_en && (wr_idx == IDX_W'(i))) begin
                    shadow_r[i] <= wr_code;
                end
            end
        end
    end

    assign active_code = active_r;

endmodule

// File: rtl/char_line_scanner.sv
// Draws one line of 8x16 glyphs in the top band of the frame: tracks the glyph row,
// prefetches glyph-ROM rows one character ahead and shifts them out as serial pixels.
module char_line_scanner
    import char_line_scanner_pkg::*;
#(
    parameter int NUM_CHARS  = 4,
    parameter int ROW_REPEAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               srst,
    char_line_scanner_if.slave bus
);

    localparam logic [1:0]       REP_LAST  = 2'(ROW_REPEAT - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(GLYPH_ROWS - 1);
    localparam logic [IDX_W-1:0] CHAR_LAST = IDX_W'(NUM_CHARS - 1);

    logic [CODE_W-1:0]  active_code_s [NUM_CHARS];

    logic [ROW_W-1:0]   row_r, row_s;
    logic [1:0]         rep_r, rep_s;
    logic               out_band_r, out_band_s;
    logic               first_line_r, first_line_s;

    scan_state_e        state_r, state_s;
    logic [IDX_W-1:0]   char_idx_r, char_idx_s;
    logic [2:0]         col_r, col_s;
    logic [GLYPH_W-1:0] shift_r, shift_s;
    logic [GLYPH_W-1:0] hold_r, hold_s;
    logic               hold_load_r, hold_load_s;
    logic [ROM_AW-1:0]  rom_addr_r, rom_addr_s;
    logic               pixel_r, pixel_s;
    logic               text_active_r, text_active_s;

    logic [4:0]         fetch_idx_s;
    logic               fetch_ok_s;
    logic [CODE_W-1:0]  fetch_code_s;

    char_text_buffer #(.NUM_CHARS(NUM_CHARS)) u_text (
        .clk         (clk),
        .rst_n       (rst_n),
        .srst        (srst),
        .frame_start (bus.frame_start),
        .wr_en       (bus.wr_en),
        .wr_idx      (bus.wr_idx),
        .wr_code     (bus.wr_code),
        .active_code (active_code_s)
    );

    // Vertical position: first line of a frame uses row 0, later lines advance rep/row
    always_comb begin
        row_s        = row_r;
        rep_s        = rep_r;
        out_band_s   = out_band_r;
        first_line_s = first_line_r;
        if (bus.frame_start) begin
            row_s        = '0;
            rep_s        = '0;
            out_band_s   = 1'b0;
            first_line_s = 1'b1;
        end else if (bus.line_start) begin
            first_line_s = 1'b0;
            if (first_line_r) begin
                rep_s = rep_r;
            end else if (rep_r == REP_LAST) begin
                rep_s = 2'd0;
                if (row_r == ROW_LAST) begin
                    out_band_s = 1'b1;
                end else begin
                    row_s = row_r + 4'd1;
                end
            end else begin
                rep_s = rep_r + 2'd1;
            end
        end else begin
            first_line_s = first_line_r;
        end
    end

    // Vertical counters register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_r        <= '0;
            rep_r        <= '0;
            out_band_r   <= 1'b0;
            first_line_r <= 1'b1;
        end else if (srst) begin
            row_r        <= '0;
            rep_r        <= '0;
            out_band_r   <= 1'b0;
            first_line_r <= 1'b1;
        end else begin
            row_r        <= row_s;
            rep_r        <= rep_s;
            out_band_r   <= out_band_s;
            first_line_r <= first_line_s;
        end
    end

    // Next character to fetch is always one ahead of the one waiting in hold
    assign fetch_idx_s = (state_r == ST_PREFETCH) ? 5'd1 : ({1'b0, char_idx_r} + 5'd2);
    assign fetch_ok_s  = (fetch_idx_s < 5'(NUM_CHARS));

    // Select the code of the character being prefetched
    always_comb begin
        fetch_code_s = '0;
        for (int i = 0; i < NUM_CHARS; i++) begin
            fetch_code_s = (fetch_idx_s == 5'(i)) ? active_code_s[i] : fetch_code_s;
        end
    end

    // Scanner next-state and datapath
    always_comb begin
        state_s       = state_r;
        char_idx_s    = char_idx_r;
        col_s         = col_r;
        shift_s       = shift_r;
        hold_s        = hold_load_r ? bus.rom_data : hold_r;
        hold_load_s   = 1'b0;
        rom_addr_s    = rom_addr_r;
        pixel_s       = pixel_r;
        text_active_s = text_active_r;
        if (bus.frame_start) begin
            state_s       = ST_IDLE;
            char_idx_s    = '0;
            col_s         = '0;
            rom_addr_s    = '0;
            pixel_s       = 1'b0;
            text_active_s = 1'b0;
        end else if (bus.line_start) begin
            char_idx_s    = '0;
            col_s         = '0;
            pixel_s       = 1'b0;
            text_active_s = 1'b0;
            if (!out_band_s) begin
                state_s    = ST_PREFETCH;
                rom_addr_s = rom_addr_f(active_code_s[0], row_s);
            end else begin
                state_s    = ST_IDLE;
                rom_addr_s = '0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                ST_PREFETCH: begin
                    state_s    = ST_LOAD;
                    shift_s    = bus.rom_data;
                    char_idx_s = '0;
                    col_s      = '0;
                    rom_addr_s = fetch_ok_s ? rom_addr_f(fetch_code_s, row_r) : rom_addr_r;
                end
                ST_LOAD: begin
                    state_s = ST_RUN;
                    hold_s  = bus.rom_data;
                end
                ST_RUN: begin
                    if (bus.pixel_en) begin
                        pixel_s       = shift_r[GLYPH_W-1];
                        text_active_s = 1'b1;
                        shift_s       = {shift_r[GLYPH_W-2:0], 1'b0};
                        col_s         = col_r + 3'd1;
                        if (col_r != 3'd7) begin
                            state_s = ST_RUN;
                        end else if (char_idx_r == CHAR_LAST) begin
                            state_s = ST_DONE;
                        end else begin
                            shift_s     = hold_r;
                            char_idx_s  = char_idx_r + 4'd1;
                            hold_load_s = 1'b1;
                            rom_addr_s  = fetch_ok_s ? rom_addr_f(fetch_code_s, row_r) : rom_addr_r;
                        end
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (bus.pixel_en) begin
                        state_s       = ST_IDLE;
                        pixel_s       = 1'b0;
                        text_active_s = 1'b0;
                    end else begin
                        state_s = ST_DONE;
                    end
                end
                default: begin
                    state_s       = ST_IDLE;
                    pixel_s       = 1'b0;
                    text_active_s = 1'b0;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else if (srst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_idx_r    <= '0;
            col_r         <= '0;
            shift_r       <= '0;
            hold_r        <= '0;
            hold_load_r   <= 1'b0;
            rom_addr_r    <= '0;
            pixel_r       <= 1'b0;
            text_active_r <= 1'b0;
        end else if (srst) begin
            char_idx_r    <= '0;
            col_r         <= '0;
            shift_r       <= '0;
            hold_r        <= '0;
            hold_load_r   <= 1'b0;
            rom_addr_r    <= '0;
            pixel_r       <= 1'b0;
            text_active_r <= 1'b0;
        end else begin
            char_idx_r    <= char_idx_s;
            col_r         <= col_s;
            shift_r       <= shift_s;
            hold_r        <= hold_s;
            hold_load_r   <= hold_load_s;
            rom_addr_r    <= rom_addr_s;
            pixel_r       <= pixel_s;
            text_active_r <= text_active_s;
        end
    end

    assign bus.rom_addr    = rom_addr_r;
    assign bus.pixel       = pixel_r;
    assign bus.text_active = text_active_r;

endmodule

// File: tb/tb_char_line_scanner.sv
// Drives two scanner configurations with shared stimulus and compares every cycle
// against a line-level model: glyph row = line_in_frame / ROW_REPEAT, pixels = ROM rows MSB-first.
module tb_char_line_scanner;

    localparam int NC_A = 4;
    localparam int RR_A = 1;
    localparam int NC_B = 1;
    localparam int RR_B = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic srst = 1'b0;

    always #5 clk = ~clk;

    char_line_scanner_if if_a ();
    char_line_scanner_if if_b ();

    char_line_scanner #(.NUM_CHARS(NC_A), .ROW_REPEAT(RR_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .srst(srst), .bus(if_a));
    char_line_scanner #(.NUM_CHARS(NC_B), .ROW_REPEAT(RR_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .srst(srst), .bus(if_b));

    function automatic logic [7:0] glyph_rom(input logic [5:0] a);
        case (a)
            6'h00:   return 8'h08;
            6'h10:   return 8'h7C;
            6'h20:   return 8'h3C;
            6'h30:   return 8'h0E;
            6'h31:   return 8'h1E;
            default: return {a[3:0], ~a[5:2]} ^ 8'h5A;
        endcase
    endfunction

    assign if_a.rom_data = glyph_rom(if_a.rom_addr);
    assign if_b.rom_data = glyph_rom(if_b.rom_addr);

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state, index 0 = dut_a, 1 = dut_b
    logic [1:0] m_shadow [2][16];
    logic [1:0] m_active [2][16];
    int         m_next_line [2];
    logic       exp_bits [2][128];
    int         q_head [2];
    int         q_len [2];
    logic       exp_pix [2];
    logic       exp_act [2];
    int         addr_phase [2];
    logic [5:0] exp_addr0 [2];
    logic [5:0] exp_addr1 [2];
    int         since_ls;

    function automatic int nc_of(input int d);
        return (d == 0) ? NC_A : NC_B;
    endfunction

    function automatic int rr_of(input int d);
        return (d == 0) ? RR_A : RR_B;
    endfunction

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) begin
                m_shadow[d][i] = 2'd0;
                m_active[d][i] = 2'd0;
            end
            m_next_line[d] = 0;
            q_head[d] = 0;
            q_len[d] = 0;
            exp_pix[d] = 1'b0;
            exp_act[d] = 1'b0;
            addr_phase[d] = 0;
        end
    endtask

    task automatic model_edge(input int d, input logic fs, input logic ls, input logic pe,
                              input logic we, input logic [3:0] wi, input logic [1:0] wc);
        int row;
        logic [7:0] g;
        if (fs) begin
            for (int i = 0; i < 16; i++) m_active[d][i] = m_shadow[d][i];
            m_next_line[d] = 0;
            q_head[d] = 0;
            q_len[d] = 0;
            exp_pix[d] = 1'b0;
            exp_act[d] = 1'b0;
            addr_phase[d] = 0;
        end else if (ls) begin
            row = m_next_line[d] / rr_of(d);
            m_next_line[d]++;
            q_head[d] = 0;
            q_len[d] = 0;
            exp_pix[d] = 1'b0;
            exp_act[d] = 1'b0;
            addr_phase[d] = 0;
            if (row < 16) begin
                for (int c = 0; c < nc_of(d); c++) begin
                    g = glyph_rom({m_active[d][c], 4'(row)});
                    for (int b = 7; b >= 0; b--) begin
                        exp_bits[d][q_len[d]] = g[b];
                        q_len[d]++;
                    end
                end
                addr_phase[d] = 1;
                exp_addr0[d] = {m_active[d][0], 4'(row)};
                exp_addr1[d] = {m_active[d][1], 4'(row)};
            end
        end else begin
            if (pe) begin
                if (q_head[d] < q_len[d]) begin
                    exp_pix[d] = exp_bits[d][q_head[d]];
                    exp_act[d] = 1'b1;
                    q_head[d]++;
                end else begin
                    exp_pix[d] = 1'b0;
                    exp_act[d] = 1'b0;
                end
            end
            addr_phase[d] = (addr_phase[d] == 1) ? 2 : 0;
        end
        if (we && (int'(wi) < nc_of(d))) m_shadow[d][wi] = wc;
    endtask

    task automatic compare_dut(input int d, input logic pix, input logic act, input logic [5:0] addr);
        check_value((d == 0) ? "a_pixel" : "b_pixel", 32'(pix), 32'(exp_pix[d]));
        check_value((d == 0) ? "a_text_active" : "b_text_active", 32'(act), 32'(exp_act[d]));
        if (addr_phase[d] == 1)
            check_value((d == 0) ? "a_rom_addr_first" : "b_rom_addr_first", 32'(addr), 32'(exp_addr0[d]));
        if ((addr_phase[d] == 2) && (nc_of(d) > 1))
            check_value((d == 0) ? "a_rom_addr_second" : "b_rom_addr_second", 32'(addr), 32'(exp_addr1[d]));
    endtask

    task automatic step(input logic fs, input logic ls, input logic pe,
                        input logic we, input logic [3:0] wi, input logic [1:0] wc);
        if_a.frame_start = fs; if_b.frame_start = fs;
        if_a.line_start  = ls; if_b.line_start  = ls;
        if_a.pixel_en    = pe; if_b.pixel_en    = pe;
        if_a.wr_en       = we; if_b.wr_en       = we;
        if_a.wr_idx      = wi; if_b.wr_idx      = wi;
        if_a.wr_code     = wc; if_b.wr_code     = wc;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) model_edge(d, fs, ls, pe, we, wi, wc);
        since_ls = ls ? 0 : since_ls + 1;
        compare_dut(0, if_a.pixel, if_a.text_active, if_a.rom_addr);
        compare_dut(1, if_b.pixel, if_b.text_active, if_b.rom_addr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0);
    endtask

    task automatic frame();
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 2'd0);
    endtask

    task automatic run_line(input int npix);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 2'd0);
        idle(2);
        for (int i = 0; i < npix; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 2'd0);
    endtask

    task automatic write_slot(input logic [3:0] wi, input logic [1:0] wc);
        step(1'b0, 1'b0, 1'b0, 1'b1, wi, wc);
    endtask

    task automatic check_all_zero(input string tag);
        check_value({tag, "_a_pixel"}, 32'(if_a.pixel), 32'd0);
        check_value({tag, "_a_active"}, 32'(if_a.text_active), 32'd0);
        check_value({tag, "_a_addr"}, 32'(if_a.rom_addr), 32'd0);
        check_value({tag, "_b_pixel"}, 32'(if_b.pixel), 32'd0);
        check_value({tag, "_b_active"}, 32'(if_b.text_active), 32'd0);
        check_value({tag, "_b_addr"}, 32'(if_b.rom_addr), 32'd0);
    endtask

    initial begin
        logic fs, ls, pe, we;
        logic [3:0] wi;
        logic [1:0] wc;
        since_ls = 100;
        if_a.frame_start = 1'b0; if_b.frame_start = 1'b0;
        if_a.line_start  = 1'b0; if_b.line_start  = 1'b0;
        if_a.pixel_en    = 1'b0; if_b.pixel_en    = 1'b0;
        if_a.wr_en       = 1'b0; if_b.wr_en       = 1'b0;
        if_a.wr_idx      = 4'd0; if_b.wr_idx      = 4'd0;
        if_a.wr_code     = 2'd0; if_b.wr_code     = 2'd0;
        model_reset();
        #22;
        check_all_zero("reset");
        rst_n = 1'b1;
        idle(2);

        // blank buffer: glyph '1' row 0 everywhere
        frame();
        run_line(12);

        // codes 0..3 in slots 0..3, plus code 3 in slot 0 of the single-char config later
        for (int i = 0; i < 4; i++) write_slot(4'(i), 2'(i));
        frame();
        run_line(36);
        idle(3);

        // row repeat: four lines, two per glyph row on the repeat-2 config
        write_slot(4'd0, 2'd3);
        frame();
        for (int l = 0; l < 4; l++) run_line(34);

        // write coinciding with frame start shows only from the following frame
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 2'd2);
        run_line(10);
        frame();
        run_line(10);

        // abort mid-line, then out-of-range write ignored
        run_line(3);
        run_line(40);
        write_slot(4'd9, 2'd1);
        frame();
        run_line(34);

        // full band and beyond: lines past the last glyph row stay blank
        frame();
        for (int l = 0; l < 34; l++) run_line(34);

        // randomized strobes and writes
        for (int i = 0; i < 5000; i++) begin
            fs = ($urandom_range(0, 1999) == 0);
            ls = ($urandom_range(0, 29) == 0);
            pe = (since_ls >= 2) && ($urandom_range(0, 9) < 8);
            we = ($urandom_range(0, 9) == 0);
            wi = 4'($urandom_range(0, 15));
            wc = 2'($urandom_range(0, 3));
            step(fs, ls, pe, we, wi, wc);
        end

        // asynchronous reset in the middle of a drawn line
        for (int i = 0; i < 4; i++) write_slot(4'(i), 2'(3 - i));
        frame();
        run_line(5);
        check_value("pre_reset_a_active", 32'(if_a.text_active), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        model_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        idle(1);
        frame();
        run_line(20);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
